// File: rtl/neuron_mac.sv
// neuron_mac: pipelined neuron (products, registered adder tree, bias+shift, ReLU/linear saturation); in: clk, rst_n, in_valid, in, weights, bias; out: out, out_valid
module neuron_mac #(
  parameter int N         = 64,
  parameter int IN_W      = 1,
  parameter int W_W       = 9,
  parameter int B_W       = 9,
  parameter int OUT_W     = 16,
  parameter int RELU      = 1,
  parameter int OUT_SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [N*IN_W-1:0]     in,
  input  logic [N*W_W-1:0]      weights,
  input  logic signed [B_W-1:0] bias,
  output logic [OUT_W-1:0]      out,
  output logic                  out_valid
);
  localparam int K = $clog2(N);
  localparam int NP = 1 << K;
  localparam int PW = IN_W + W_W + 1;
  localparam int ACC_W = IN_W + W_W + K + 2;
  localparam int SW = (ACC_W > B_W ? ACC_W : B_W) + 1;
  localparam int EW = SW > OUT_W + 2 ? SW : OUT_W + 2;
  localparam logic signed [EW-1:0] ONE = EW'(1);
  localparam logic signed [EW-1:0] HI = (ONE <<< (RELU != 0 ? OUT_W : OUT_W - 1)) - ONE;
  localparam logic signed [EW-1:0] LO = RELU != 0 ? '0 : -(ONE <<< (OUT_W - 1));
  logic signed [ACC_W-1:0] leaf [NP];
  logic signed [ACC_W-1:0] node_q [2*NP-1];
  logic signed [ACC_W-1:0] node_d [2*NP-1];
  logic signed [B_W-1:0]   bias_q [K+1];
  logic [K+1:0]            vld_q;
  logic signed [SW-1:0]    sum_d, s_d, s_q;
  logic signed [EW-1:0]    se;
  logic [OUT_W-1:0]        out_d, out_q;
  logic                    ovld_q;
  for (genvar i = 0; i < NP; i++) begin : g_leaf
    if (i < N) begin : g_p
      assign leaf[i] = ACC_W'(PW'($signed({1'b0, in[(i+1)*IN_W-1 -: IN_W]})) *
                              PW'($signed(weights[(i+1)*W_W-1 -: W_W])));
    end else begin : g_z
      assign leaf[i] = '0;
    end
  end
  always_comb begin
    for (int j = 0; j < NP - 1; j++) node_d[j] = node_q[2*j+1] + node_q[2*j+2];
    for (int j = 0; j < NP; j++) node_d[NP-1+j] = leaf[j];
  end
  assign sum_d = SW'(node_q[0]) + SW'(bias_q[K]);
  assign s_d   = sum_d >>> OUT_SHIFT;
  assign se    = EW'(s_q);
  assign out_d = se > HI ? OUT_W'(HI) : se < LO ? OUT_W'(LO) : OUT_W'(se);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2*NP-1; j++) node_q[j] <= '0;
      for (int j = 0; j <= K; j++) bias_q[j] <= '0;
      vld_q  <= '0;
      s_q    <= '0;
      out_q  <= '0;
      ovld_q <= 1'b0;
    end else begin
      node_q    <= node_d;
      bias_q[0] <= bias;
      for (int j = 1; j <= K; j++) bias_q[j] <= bias_q[j-1];
      vld_q  <= {vld_q[K:0], in_valid};
      s_q    <= s_d;
      out_q  <= out_d;
      ovld_q <= vld_q[K+1];
    end
  end
  assign out       = out_q;
  assign out_valid = ovld_q;
endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: checks hidden (N=64, ReLU) and output (N=100, linear) neuron configurations against a behavioural model
module tb_neuron_mac;
  localparam int HL = 8;
  localparam int OL = 9;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          rst_n;
  logic          h_vi, h_ov;
  logic [63:0]   h_in;
  logic [575:0]  h_w;
  logic [8:0]    h_b;
  logic [15:0]   h_out;
  logic          o_vi, o_ov;
  logic [1599:0] o_in;
  logic [899:0]  o_w;
  logic [8:0]    o_b;
  logic [21:0]   o_out;
  int checks = 0;
  int errors = 0;
  int ec = 0;
  bit     hv [4096];
  longint hx [4096];
  bit     ov [4096];
  longint ox [4096];
  neuron_mac #(.N(64), .IN_W(1), .W_W(9), .B_W(9), .OUT_W(16), .RELU(1), .OUT_SHIFT(0)) u_hid (
    .clk(clk), .rst_n(rst_n), .in_valid(h_vi), .in(h_in), .weights(h_w), .bias(h_b),
    .out(h_out), .out_valid(h_ov));
  neuron_mac #(.N(100), .IN_W(16), .W_W(9), .B_W(9), .OUT_W(22), .RELU(0), .OUT_SHIFT(0)) u_out (
    .clk(clk), .rst_n(rst_n), .in_valid(o_vi), .in(o_in), .weights(o_w), .bias(o_b),
    .out(o_out), .out_valid(o_ov));
  function automatic longint sat(input longint s, input int w, input bit relu);
    longint hi, lo;
    hi = relu ? (64'sd1 <<< w) - 1 : (64'sd1 <<< (w - 1)) - 1;
    lo = relu ? 64'sd0 : -(64'sd1 <<< (w - 1));
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic clr_h;
    h_in = '0; h_w = '0; h_b = '0;
  endtask
  task automatic clr_o;
    o_in = '0; o_w = '0; o_b = '0;
  endtask
  task automatic rand_h;
    h_in = {$urandom, $urandom};
    for (int i = 0; i < 64; i++) h_w[i*9 +: 9] = 9'($urandom);
    h_b = 9'($urandom);
  endtask
  task automatic rand_o(input int maxv);
    for (int i = 0; i < 100; i++) begin
      o_in[i*16 +: 16] = 16'($urandom_range(0, maxv));
      o_w[i*9 +: 9] = 9'($urandom);
    end
    o_b = 9'($urandom);
  endtask
  always @(posedge clk) begin : model
    longint a;
    a = longint'($signed(h_b));
    for (int i = 0; i < 64; i++) if (h_in[i]) a += longint'($signed(h_w[i*9 +: 9]));
    hv[ec] = h_vi && rst_n;
    hx[ec] = sat(a, 16, 1'b1);
    a = longint'($signed(o_b));
    for (int i = 0; i < 100; i++) a += longint'(o_in[i*16 +: 16]) * longint'($signed(o_w[i*9 +: 9]));
    ov[ec] = o_vi && rst_n;
    ox[ec] = sat(a, 22, 1'b0);
    ec++;
  end
  always @(negedge rst_n) begin
    for (int i = 0; i < 4096; i++) begin
      hv[i] = 1'b0;
      ov[i] = 1'b0;
    end
  end
  always @(negedge clk) begin : compare
    int e;
    bit he, oe;
    e = ec - 1;
    if (ec > 0) begin
      if (!rst_n) begin
        chk("rst_h_out", longint'(h_out), 0);
        chk("rst_h_vld", longint'(h_ov), 0);
        chk("rst_o_out", longint'(o_out), 0);
        chk("rst_o_vld", longint'(o_ov), 0);
      end else begin
        he = e >= HL ? hv[e-HL] : 1'b0;
        oe = e >= OL ? ov[e-OL] : 1'b0;
        chk("h_vld", longint'(h_ov), longint'(he));
        if (he) chk("h_out", longint'(h_out), hx[e-HL]);
        chk("o_vld", longint'(o_ov), longint'(oe));
        if (oe) chk("o_out", longint'($signed(o_out)), ox[e-OL]);
      end
    end
  end
  longint exp_o [4];
  int cnt;
  initial begin
    rst_n = 1'b0; h_vi = 1'b0; o_vi = 1'b0;
    clr_h; clr_o;
    repeat (5) begin
      rand_h; rand_o(65535);
      h_vi = 1'b1; o_vi = 1'b1;
      step;
    end
    rst_n = 1'b1; h_vi = 1'b0; o_vi = 1'b0;
    clr_h; clr_o;
    repeat (HL) step;
    h_in = '1;
    for (int i = 0; i < 64; i++) h_w[i*9 +: 9] = 9'h001;
    h_b = 9'd5; h_vi = 1'b1;
    step;
    h_vi = 1'b0;
    repeat (HL) step;
    @(negedge clk);
    chk("h_69_vld", longint'(h_ov), 1);
    chk("h_69", longint'(h_out), 69);
    step;
    @(negedge clk);
    chk("h_69_pulse", longint'(h_ov), 0);
    h_in = '1;
    for (int i = 0; i < 64; i++) h_w[i*9 +: 9] = 9'h1FF;
    h_b = 9'd0; h_vi = 1'b1;
    step;
    h_in = '0; h_b = 9'h0FF;
    step;
    clr_h; h_in[0] = 1'b1; h_w[8:0] = 9'h1FF;
    step;
    clr_h;
    step;
    h_vi = 1'b0;
    repeat (HL - 3) step;
    @(negedge clk);
    chk("h_relu_neg_vld", longint'(h_ov), 1);
    chk("h_relu_neg", longint'(h_out), 0);
    step;
    @(negedge clk);
    chk("h_bias255", longint'(h_out), 255);
    step;
    @(negedge clk);
    chk("h_relu_m1", longint'(h_out), 0);
    step;
    @(negedge clk);
    chk("h_zero_vld", longint'(h_ov), 1);
    chk("h_zero", longint'(h_out), 0);
    o_in = '1;
    for (int i = 0; i < 100; i++) o_w[i*9 +: 9] = 9'h0FF;
    o_vi = 1'b1;
    step;
    for (int i = 0; i < 100; i++) o_w[i*9 +: 9] = 9'h100;
    step;
    o_vi = 1'b0;
    clr_o;
    repeat (OL - 1) step;
    @(negedge clk);
    chk("o_sat_hi", longint'(o_out), 64'h1FFFFF);
    step;
    @(negedge clk);
    chk("o_sat_lo", longint'(o_out), 64'h200000);
    clr_o; o_in[15:0] = 16'd3; o_w[8:0] = 9'h1FE; o_b = 9'd7; o_vi = 1'b1;
    step;
    clr_o; o_in[5*16 +: 16] = 16'd10; o_w[5*9 +: 9] = 9'd4; o_b = 9'h1FF;
    step;
    clr_o; o_b = 9'h1FD;
    step;
    o_vi = 1'b0; clr_o;
    repeat (OL - 2) step;
    exp_o = '{1, 39, -3, 0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("o_stream%0d_vld", k), longint'(o_ov), 1);
      chk($sformatf("o_stream%0d", k), longint'($signed(o_out)), exp_o[k]);
      step;
    end
    exp_o = '{2097151, 2097151, -2097152, -2097152};
    o_vi = 1'b1;
    o_in[15:0] = 16'hFFFF; o_w[8:0] = 9'd32;   o_b = 9'h01F; step;
    o_b = 9'h020; step;
    o_w[8:0] = 9'h1E0; o_b = 9'h1E0; step;
    o_b = 9'h1DF; step;
    o_vi = 1'b0; clr_o;
    repeat (OL - 3) step;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("o_bound%0d", k), longint'($signed(o_out)), exp_o[k]);
      step;
    end
    for (int k = 0; k < 40; k++) begin
      rand_h; rand_o(k % 2 ? 65535 : 300);
      h_vi = 1'($urandom); o_vi = 1'($urandom);
      step;
    end
    h_vi = 1'b0; o_vi = 1'b0;
    repeat (OL + 2) step;
    repeat (4) begin
      rand_h; rand_o(200);
      h_vi = 1'b1; o_vi = 1'b1;
      step;
    end
    rst_n = 1'b0; h_vi = 1'b0; o_vi = 1'b0;
    step;
    rst_n = 1'b1;
    cnt = 0;
    repeat (OL + 2) begin
      @(negedge clk);
      cnt += int'(h_ov) + int'(o_ov);
      step;
    end
    chk("rst_flush", longint'(cnt), 0);
    clr_h; h_in = '1;
    for (int i = 0; i < 64; i++) h_w[i*9 +: 9] = 9'h001;
    h_b = 9'd5; h_vi = 1'b1;
    step;
    h_vi = 1'b0;
    for (int k = 1; k <= HL; k++) begin
      step;
      @(negedge clk);
      chk($sformatf("h_post_rst_vld%0d", k), longint'(h_ov), longint'(k == HL));
      if (k == HL) chk("h_post_rst", longint'(h_out), 69);
    end
    repeat (3) step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
